// File: rtl/excp_flush_ctrl_pkg.sv
// Shared definitions for the exception flush controller: state encoding,
// default field widths and a width helper for index/counter vectors.
package excp_flush_ctrl_pkg;

  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_ECODE_W    = 6;
  localparam int DEF_PC_W       = 32;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_PEND  = 2'd1,
    FC_DRAIN = 2'd2
  } fc_state_e;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/excp_flush_ctrl_if.sv
// Pipeline-side bundle of the flush controller: per-stage exception reports,
// WB commit strobes, and the flush/kill/redirect outputs plus latched record.
interface excp_flush_ctrl_if
  import excp_flush_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int ECODE_W    = DEF_ECODE_W,
  parameter int PC_W       = DEF_PC_W
) ();
  localparam int STAGE_W = clog2_min1(NUM_STAGES);

  logic [NUM_STAGES-1:0]         excp_valid;
  logic [NUM_STAGES*ECODE_W-1:0] excp_ecode;
  logic [NUM_STAGES*PC_W-1:0]    excp_pc;
  logic                          excp_commit;
  logic                          ertn_commit;

  logic                          global_flush_flag;
  logic [NUM_STAGES-1:0]         stage_kill;
  logic                          flush_redirect;
  logic                          redirect_is_ertn;
  logic [ECODE_W-1:0]            excp_ecode_q;
  logic [PC_W-1:0]               excp_pc_q;
  logic [STAGE_W-1:0]            excp_stage_q;
  logic                          flush_busy;

  // Pipeline / commit side.
  modport master (
    output excp_valid, excp_ecode, excp_pc, excp_commit, ertn_commit,
    input  global_flush_flag, stage_kill, flush_redirect, redirect_is_ertn,
    input  excp_ecode_q, excp_pc_q, excp_stage_q, flush_busy
  );

  // Flush controller side.
  modport slave (
    input  excp_valid, excp_ecode, excp_pc, excp_commit, ertn_commit,
    output global_flush_flag, stage_kill, flush_redirect, redirect_is_ertn,
    output excp_ecode_q, excp_pc_q, excp_stage_q, flush_busy
  );
endinterface

// File: rtl/excp_flush_ctrl_oldest_sel.sv
// Priority encoder picking the oldest (highest-index) reporting stage.
module excp_flush_ctrl_oldest_sel #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Ascending scan so the last (highest) set bit overrides younger ones.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/excp_flush_ctrl.sv
// Exception flush controller: selects the oldest excepting stage, holds the
// flush until WB commits the exception/ERTN, then drains for DRAIN_CYCLES
// and emits a one-cycle fetch redirect pulse.
module excp_flush_ctrl
  import excp_flush_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int ECODE_W      = DEF_ECODE_W,
  parameter int PC_W         = DEF_PC_W,
  parameter int DRAIN_CYCLES = 1
) (
  input logic               clk,
  input logic               resetn,
  excp_flush_ctrl_if.slave  bus
);
  localparam int STAGE_W = clog2_min1(NUM_STAGES);
  localparam int CNT_W   = clog2_min1(DRAIN_CYCLES + 1);

  fc_state_e          state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               latch_en;
  logic               flush_flag;
  logic [NUM_STAGES-1:0] kill;
  logic [NUM_STAGES-1:0] below_win;

  logic               any_excp;
  logic [STAGE_W-1:0] win;
  logic [ECODE_W-1:0] win_ecode;
  logic [PC_W-1:0]    win_pc;
  logic               commit;
  logic               accept;

  logic               redirect_q, is_ertn_q;
  logic [ECODE_W-1:0] ecode_q;
  logic [PC_W-1:0]    pc_q;
  logic [STAGE_W-1:0] stage_q;

  excp_flush_ctrl_oldest_sel #(.N(NUM_STAGES), .IDX_W(STAGE_W)) u_sel (
    .valid (bus.excp_valid),
    .any   (any_excp),
    .idx   (win)
  );

  assign win_ecode = bus.excp_ecode[int'(win)*ECODE_W +: ECODE_W];
  assign win_pc    = bus.excp_pc[int'(win)*PC_W +: PC_W];
  assign commit    = bus.excp_commit | bus.ertn_commit;
  // Commits seen while draining belong to the flushed window and are dropped.
  assign accept    = commit & (state != FC_DRAIN);

  // Kill every stage younger than the winner; the winner itself survives.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
    assign below_win[gi] = (gi < int'(win));
  end

  // Next-state, drain counter and combinational flush/kill outputs.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_en   = 1'b0;
    flush_flag = 1'b0;
    kill       = '0;
    case (state)
      FC_IDLE: begin
        flush_flag = any_excp & ~commit;
        kill       = any_excp ? below_win : '0;
        if (commit) begin
          state_next = FC_DRAIN;
          cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
        end else if (any_excp) begin
          state_next = FC_PEND;
          latch_en   = 1'b1;
        end
      end
      FC_PEND: begin
        flush_flag = ~commit;
        kill       = any_excp ? below_win : '1;
        if (commit) begin
          state_next = FC_DRAIN;
          cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      FC_DRAIN: begin
        flush_flag = 1'b1;
        kill       = '1;
        if (cnt != '0) cnt_next = cnt - CNT_W'(1);
        else           state_next = FC_IDLE;
      end
      default: state_next = FC_IDLE;
    endcase
  end

  // State, counter, redirect pulse and latched exception record.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= FC_IDLE;
      cnt        <= '0;
      redirect_q <= 1'b0;
      is_ertn_q  <= 1'b0;
      ecode_q    <= '0;
      pc_q       <= '0;
      stage_q    <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      redirect_q <= accept;
      is_ertn_q  <= accept & bus.ertn_commit;
      if (latch_en) begin
        ecode_q <= win_ecode;
        pc_q    <= win_pc;
        stage_q <= win;
      end
    end
  end

  assign bus.global_flush_flag = flush_flag;
  assign bus.stage_kill        = kill;
  assign bus.flush_redirect    = redirect_q;
  assign bus.redirect_is_ertn  = is_ertn_q;
  assign bus.excp_ecode_q      = ecode_q;
  assign bus.excp_pc_q         = pc_q;
  assign bus.excp_stage_q      = stage_q;
  assign bus.flush_busy        = (state != FC_IDLE);

endmodule
